// File: rtl/xrv_pkg.sv
// Shared types and constants for the RV32M issue/control block.
// Holds the funct3 decode, the control FSM states and the fixed divide results.
package xrv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_DIV_WAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_RESP     = 3'd4
  } muldiv_state_e;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/xrv_div_special.sv
// Combinational detection of divide cases resolved without the divider engine:
// divide-by-zero and signed INT_MIN / -1 overflow, with their architectural results.
module xrv_div_special
  import xrv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_funct3,
  output logic            o_is_special,
  output logic [XLEN-1:0] o_special_result
);

  muldiv_op_e w_op;
  logic       w_div0;
  logic       w_ovf;

  assign w_op   = muldiv_op_e'(i_funct3);
  assign w_div0 = (i_rs2 == '0);
  assign w_ovf  = (i_rs1 == XLEN'(INT_MIN)) && (i_rs2 == {XLEN{1'b1}});

  always_comb begin
    o_is_special     = 1'b0;
    o_special_result = '0;
    unique case (w_op)
      OP_DIV: begin
        o_is_special     = w_div0 | w_ovf;
        o_special_result = w_div0 ? XLEN'(DIV0_Q) : XLEN'(INT_MIN);
      end
      OP_DIVU: begin
        o_is_special     = w_div0;
        o_special_result = XLEN'(DIV0_Q);
      end
      OP_REM: begin
        // overflow remainder is zero, which is already the default result
        o_is_special     = w_div0 | w_ovf;
        o_special_result = w_div0 ? i_rs1 : '0;
      end
      OP_REMU: begin
        o_is_special     = w_div0;
        o_special_result = i_rs1;
      end
      default: begin
        o_is_special     = 1'b0;
        o_special_result = '0;
      end
    endcase
  end

endmodule

// File: rtl/xrv_muldiv_ctrl.sv
// Issue stage for RV32M ops: captures operands, pulses the mult/div engine, resolves
// divide special cases locally and holds the result until writeback takes it.
module xrv_muldiv_ctrl
  import xrv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int WDOG_CYCLES = 63
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            i_ex_valid,
  output logic            o_ex_ready,
  input  logic [2:0]      i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_rs1,
  input  logic [XLEN-1:0] i_ex_rs2,
  input  logic [4:0]      i_ex_rd,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_mul_a,
  output logic [XLEN-1:0] o_mul_b,
  output logic [2:0]      o_mul_type,
  output logic            o_mul_valid,
  input  logic [XLEN-1:0] i_mul_result,
  input  logic            i_mul_result_valid,
  output logic [XLEN-1:0] o_div_dividend,
  output logic [XLEN-1:0] o_div_divisor,
  output logic            o_div_is_sign,
  output logic            o_div_optype,
  output logic            o_div_valid,
  input  logic [XLEN-1:0] i_div_result,
  input  logic            i_div_result_valid,
  output logic            o_wb_valid,
  input  logic            i_wb_ready,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_busy,
  output logic            o_wdog_err
);

  muldiv_state_e   r_state;
  muldiv_state_e   w_state_nxt;
  logic [5:0]      r_wdog;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [4:0]      r_rd;
  logic            r_is_div;
  logic [2:0]      r_mul_type;
  logic            r_div_is_sign;
  logic            r_div_optype;
  logic            r_mul_valid;
  logic            r_div_valid;
  logic [XLEN-1:0] r_wb_data;
  logic            r_wdog_err;

  logic            w_accept;
  logic            w_is_mul;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_res_vld;
  logic [XLEN-1:0] w_res_dat;
  logic            w_wdog_exp;
  logic            w_wdog_clr;
  logic            w_set_err;
  logic            w_ld_res;
  logic            w_ld_zero;

  xrv_div_special #(
    .XLEN (XLEN)
  ) u_div_special (
    .i_rs1            (i_ex_rs1),
    .i_rs2            (i_ex_rs2),
    .i_funct3         (i_ex_funct3),
    .o_is_special     (w_special),
    .o_special_result (w_special_res)
  );

  assign o_ex_ready = (r_state == ST_IDLE) & ~i_flush;
  assign w_accept   = i_ex_valid & o_ex_ready;
  assign w_is_mul   = ~i_ex_funct3[2];

  // Only the engine that was started for the op in flight can complete it.
  assign w_res_vld  = r_is_div ? i_div_result_valid : i_mul_result_valid;
  assign w_res_dat  = r_is_div ? i_div_result : i_mul_result;
  assign w_wdog_exp = (r_wdog == 6'(WDOG_CYCLES));

  always_comb begin
    w_state_nxt = r_state;
    w_wdog_clr  = 1'b0;
    w_set_err   = 1'b0;
    w_ld_res    = 1'b0;
    w_ld_zero   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_wdog_clr = 1'b1;
          if (w_is_mul)       w_state_nxt = ST_MUL_WAIT;
          else if (w_special) w_state_nxt = ST_RESP;
          else                w_state_nxt = ST_DIV_WAIT;
        end
      end
      ST_MUL_WAIT, ST_DIV_WAIT: begin
        // A result landing with the flush is already the discarded one; no drain needed.
        if (w_res_vld) begin
          w_state_nxt = i_flush ? ST_IDLE : ST_RESP;
          w_ld_res    = ~i_flush;
        end else if (i_flush) begin
          w_state_nxt = ST_DRAIN;
          w_wdog_clr  = 1'b1;
        end else if (w_wdog_exp) begin
          w_state_nxt = ST_RESP;
          w_set_err   = 1'b1;
          w_ld_zero   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_res_vld) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wdog_exp) begin
          w_state_nxt = ST_IDLE;
          w_set_err   = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_wb_ready | i_flush) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= ST_IDLE;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wdog_clr)
        r_wdog <= '0;
      else if (r_state == ST_MUL_WAIT || r_state == ST_DIV_WAIT || r_state == ST_DRAIN)
        r_wdog <= r_wdog + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_is_div      <= 1'b0;
      r_mul_type    <= '0;
      r_div_is_sign <= 1'b0;
      r_div_optype  <= 1'b0;
      r_mul_valid   <= 1'b0;
      r_div_valid   <= 1'b0;
      r_wb_data     <= '0;
      r_wdog_err    <= 1'b0;
    end else begin
      r_mul_valid <= w_accept & w_is_mul;
      r_div_valid <= w_accept & ~w_is_mul & ~w_special;
      if (w_accept) begin
        r_rs1         <= i_ex_rs1;
        r_rs2         <= i_ex_rs2;
        r_rd          <= i_ex_rd;
        r_is_div      <= ~w_is_mul;
        r_mul_type    <= {1'b0, i_ex_funct3[1:0]};
        r_div_is_sign <= ~i_ex_funct3[0];
        r_div_optype  <= i_ex_funct3[1];
        // Preloaded with the shortcut value; engine ops overwrite it on completion.
        r_wb_data     <= w_special_res;
      end else if (w_ld_res) begin
        r_wb_data <= w_res_dat;
      end else if (w_ld_zero) begin
        r_wb_data <= '0;
      end
      if (w_set_err) r_wdog_err <= 1'b1;
    end
  end

  assign o_mul_a        = r_rs1;
  assign o_mul_b        = r_rs2;
  assign o_mul_type     = r_mul_type;
  assign o_mul_valid    = r_mul_valid;
  assign o_div_dividend = r_rs1;
  assign o_div_divisor  = r_rs2;
  assign o_div_is_sign  = r_div_is_sign;
  assign o_div_optype   = r_div_optype;
  assign o_div_valid    = r_div_valid;
  assign o_wb_valid     = (r_state == ST_RESP);
  assign o_wb_rd        = r_rd;
  assign o_wb_data      = r_wb_data;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_wdog_err     = r_wdog_err;

endmodule

// File: tb/tb_xrv_muldiv_ctrl.sv
// Bench for xrv_muldiv_ctrl: vector table with an engine responder and a writeback
// scoreboard, plus hand sequences for backpressure, flush, watchdog and reset.
module tb_xrv_muldiv_ctrl;
  import xrv_pkg::*;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        i_ex_valid = 1'b0;
  logic        o_ex_ready;
  logic [2:0]  i_ex_funct3 = '0;
  logic [31:0] i_ex_rs1 = '0;
  logic [31:0] i_ex_rs2 = '0;
  logic [4:0]  i_ex_rd = '0;
  logic        i_flush = 1'b0;
  logic [31:0] o_mul_a, o_mul_b;
  logic [2:0]  o_mul_type;
  logic        o_mul_valid;
  logic [31:0] i_mul_result = '0;
  logic        i_mul_result_valid = 1'b0;
  logic [31:0] o_div_dividend, o_div_divisor;
  logic        o_div_is_sign, o_div_optype, o_div_valid;
  logic [31:0] i_div_result = '0;
  logic        i_div_result_valid = 1'b0;
  logic        o_wb_valid;
  logic        i_wb_ready = 1'b1;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_busy, o_wdog_err;

  always #5 clk = ~clk;

  xrv_muldiv_ctrl #(.XLEN(32), .WDOG_CYCLES(63)) dut (
    .clk(clk), .rstb(rstb),
    .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready), .i_ex_funct3(i_ex_funct3),
    .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2), .i_ex_rd(i_ex_rd), .i_flush(i_flush),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .o_mul_type(o_mul_type), .o_mul_valid(o_mul_valid),
    .i_mul_result(i_mul_result), .i_mul_result_valid(i_mul_result_valid),
    .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
    .o_div_is_sign(o_div_is_sign), .o_div_optype(o_div_optype), .o_div_valid(o_div_valid),
    .i_div_result(i_div_result), .i_div_result_valid(i_div_result_valid),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_busy(o_busy), .o_wdog_err(o_wdog_err)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] exp;   // expected wb_data; also what the engine model returns
    int          eng;   // 0 none, 1 mult, 2 div
    int          lat;   // engine cycles from start pulse to result_valid
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t  sb[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_wb(input string name);
    wb_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb: got wb_valid expected none", name);
    end else begin
      e = sb.pop_front();
      check({name, "_rd"}, 64'(o_wb_rd), 64'(e.rd));
      check({name, "_data"}, 64'(o_wb_data), 64'(e.data));
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ex_ready"}, 64'(o_ex_ready), 64'd1);
    check({name, "_outs"},
          {o_mul_a, o_mul_b} | 64'(o_div_dividend) | 64'(o_div_divisor) | 64'(o_wb_data), 64'd0);
    check({name, "_ctl"},
          64'({o_mul_type, o_mul_valid, o_div_is_sign, o_div_optype, o_div_valid,
               o_wb_valid, o_wb_rd, o_busy, o_wdog_err}), 64'd0);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    i_ex_valid = 1'b1; i_ex_funct3 = f3; i_ex_rs1 = a; i_ex_rs2 = b; i_ex_rd = rd;
    @(negedge clk);
    i_ex_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int    mulc = 0, divc = 0, pulse_k = -1, k = 1;
    bit    done = 1'b0;
    string n = $sformatf("v%0d", idx);
    @(negedge clk);
    check({n, "_ex_ready"}, 64'(o_ex_ready), 64'd1);
    i_ex_valid = 1'b1; i_ex_funct3 = v.f3; i_ex_rs1 = v.rs1; i_ex_rs2 = v.rs2; i_ex_rd = v.rd;
    sb.push_back('{v.rd, v.exp});
    @(negedge clk);
    i_ex_valid = 1'b0;
    while (!done && k < 100) begin
      i_mul_result_valid = 1'b0;
      i_div_result_valid = 1'b0;
      if (o_mul_valid) begin
        mulc++;
        if (pulse_k < 0) begin
          pulse_k = k;
          check({n, "_mul_ops"}, {o_mul_a, o_mul_b}, {v.rs1, v.rs2});
          check({n, "_mul_type"}, 64'(o_mul_type), 64'({1'b0, v.f3[1:0]}));
        end
      end
      if (o_div_valid) begin
        divc++;
        if (pulse_k < 0) begin
          pulse_k = k;
          check({n, "_div_ops"}, {o_div_dividend, o_div_divisor}, {v.rs1, v.rs2});
          check({n, "_div_cfg"}, 64'({o_div_is_sign, o_div_optype}), 64'({~v.f3[0], v.f3[1]}));
        end
      end
      if (pulse_k >= 0 && k == pulse_k + v.lat) begin
        if (v.eng == 1) begin i_mul_result_valid = 1'b1; i_mul_result = v.exp; end
        if (v.eng == 2) begin i_div_result_valid = 1'b1; i_div_result = v.exp; end
      end
      if (o_wb_valid) begin
        done = 1'b1;
        check({n, "_latency"}, 64'(k), 64'((v.eng == 0) ? 1 : v.lat + 2));
        check_wb(n);
      end else begin
        @(negedge clk);
        k++;
      end
    end
    i_mul_result_valid = 1'b0;
    i_div_result_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no wb_valid expected wb_valid within 100 cycles", n);
    end
    check({n, "_pulses"}, 64'({mulc, divc}), 64'({(v.eng == 1) ? 1 : 0, (v.eng == 2) ? 1 : 0}));
    @(negedge clk);
    check({n, "_idle"}, 64'({o_busy, o_ex_ready}), 64'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  k;
    bit  seen;
    vecs[0]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 1, 3};  // MULHU
    vecs[1]  = '{3'd0, 32'd3,         32'd5,         5'd1,  32'h0000_000F, 1, 1};  // MUL
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         5'd2,  32'hFFFF_FFFF, 1, 2};  // MULH -1*2
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 1, 4};  // MULHSU
    vecs[4]  = '{3'd4, 32'd7,         32'd0,         5'd6,  32'hFFFF_FFFF, 0, 0};  // DIV /0
    vecs[5]  = '{3'd7, 32'd7,         32'd0,         5'd8,  32'h0000_0007, 0, 0};  // REMU /0
    vecs[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 0, 0};  // DIV ovf
    vecs[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 0, 0};  // REM ovf
    vecs[8]  = '{3'd5, 32'd100,       32'd7,         5'd12, 32'h0000_000E, 2, 5};  // DIVU
    vecs[9]  = '{3'd6, 32'h8000_0000, 32'd1,         5'd13, 32'h0000_0000, 2, 2};  // REM by 1
    vecs[10] = '{3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'h0000_0001, 2, 1};  // DIV -1/-1
    vecs[11] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 2, 2};  // DIVU no ovf

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rstb = 1'b1;

    for (int i = 0; i < 12; i++) run_op(vecs[i], i);

    // Backpressure hold, with a stray multiplier done pulse during DIV_WAIT.
    i_wb_ready = 1'b0;
    sb.push_back('{5'd9, 32'hFFFF_FFFD});
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
    check("hold_div_pulse", 64'(o_div_valid), 64'd1);
    @(negedge clk);
    i_mul_result_valid = 1'b1; i_mul_result = 32'hDEAD_BEEF;
    @(negedge clk);
    i_mul_result_valid = 1'b0;
    i_div_result_valid = 1'b1; i_div_result = 32'hFFFF_FFFD;
    @(negedge clk);
    i_div_result_valid = 1'b0;
    check("hold_first", 64'(o_wb_valid), 64'd1);
    check_wb("hold");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("hold_c%0d", c), {o_wb_valid, o_wb_rd, o_wb_data}, {1'b1, 5'd9, 32'hFFFF_FFFD});
    end
    i_wb_ready = 1'b1;
    @(negedge clk);
    check("hold_release", 64'({o_wb_valid, o_busy, o_ex_ready}), 64'b001);

    // Flush during DIV_WAIT: result arrives 10 cycles after the start pulse and is dropped.
    issue(3'd5, 32'd100, 32'd7, 5'd3);
    check("drain_pulse", 64'(o_div_valid), 64'd1);
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    seen = 1'b0;
    for (k = 3; k <= 11; k++) begin
      seen = seen | o_wb_valid | o_ex_ready | ~o_busy;
      if (k == 11) begin i_div_result_valid = 1'b1; i_div_result = 32'h0000_000E; end
      @(negedge clk);
    end
    i_div_result_valid = 1'b0;
    check("drain_blocked", 64'(seen), 64'd0);
    check("drain_done", 64'({o_wb_valid, o_busy, o_ex_ready}), 64'b001);

    // Flush in RESP drops the result; flush in IDLE blocks acceptance.
    i_wb_ready = 1'b0;
    issue(3'd4, 32'd7, 32'd0, 5'd17);
    check("resp_flush_pre", 64'(o_wb_valid), 64'd1);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("resp_flush_post", 64'({o_wb_valid, o_busy}), 64'b00);
    i_ex_valid = 1'b1; i_ex_funct3 = 3'd0; i_flush = 1'b1;
    #1 check("idle_flush_ready", 64'(o_ex_ready), 64'd0);
    @(negedge clk);
    i_ex_valid = 1'b0; i_flush = 1'b0;
    check("idle_flush_nop", 64'({o_busy, o_mul_valid}), 64'b00);
    i_wb_ready = 1'b1;

    // Watchdog: silent multiplier.
    sb.push_back('{5'd7, 32'd0});
    issue(3'd0, 32'd2, 32'd3, 5'd7);
    k = 1;
    while (!o_wb_valid && k < 150) begin
      if (k == 40) check("wdog_early", 64'(o_wdog_err), 64'd0);
      @(negedge clk);
      k++;
    end
    check("wdog_fired", 64'({o_wb_valid, o_wdog_err}), 64'b11);
    check("wdog_window", 64'(k >= 63 && k <= 66), 64'd1);
    check_wb("wdog");
    @(negedge clk);
    check("wdog_sticky", 64'({o_wdog_err, o_busy}), 64'b10);

    // Async reset mid-op; the late engine result must be ignored.
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21);
    #2 rstb = 1'b0;
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    rstb = 1'b1;
    i_mul_result_valid = 1'b1; i_mul_result = 32'h5555_5555;
    @(negedge clk);
    i_mul_result_valid = 1'b0;
    @(negedge clk);
    check("post_reset_quiet", 64'({o_wb_valid, o_busy, o_ex_ready}), 64'b001);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
